// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a load/store requester and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency doubleword data memory: one access in flight, single-cycle response strobe.
//
// state | meaning
// IDLE  | ready for a new request
// WAIT  | request latched, counting down remaining latency
// RESP  | response strobe cycle; stores have committed
module data_mem_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 3
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         LAT_ONE  = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             wr_q;
  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  logic [63:0]      mem [DEPTH];

  logic             accept;
  logic             enter_resp;
  logic             cur_wr;
  logic [63:0]      cur_addr;
  logic [63:0]      cur_wdata;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic             q_err;
  logic [IDX_W-1:0] q_idx;

  function automatic logic addr_err(input logic [63:0] a);
    return (a[2:0] != 3'd0) || (a[63:3] >= 61'(DEPTH));
  endfunction

  assign accept     = bus.req_valid && (state == IDLE);
  assign enter_resp = (accept && LAT_ONE) || ((state == WAIT) && (cnt == 4'd0));

  // With LATENCY 1 the commit edge is the acceptance edge, so use the live request.
  always_comb begin
    cur_wr    = wr_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_wr    = bus.req_write;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end
  end

  assign cur_err = addr_err(cur_addr);
  assign cur_idx = cur_addr[IDX_W+2:3];
  assign q_err   = addr_err(addr_q);
  assign q_idx   = addr_q[IDX_W+2:3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (LAT_ONE) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
    end else if (enter_resp && cur_wr && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.stall      = ((state == IDLE) && bus.req_valid) || (state == WAIT);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && q_err;
  assign bus.resp_rdata = ((state == RESP) && !wr_q && !q_err) ? mem[q_idx] : 64'd0;

endmodule
